alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 49 ++++
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle between alu_arbiter and its environment: two requesters, the shared ALU, and the response port.
// slave is the arbiter's view; master is the view of whoever drives requests, the ALU and the consumer.
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [3:0]        req0_sel;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [3:0]        req1_sel;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_sel;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carryOut;
  logic              alu_overflow;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic [2:0]        rsp_flags;
  logic              rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_result, alu_carryOut, alu_overflow, alu_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_result, alu_carryOut, alu_overflow, alu_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional macro ALU_ARB_SELCHK_EN turns illegal selects into an error response with zero result/flags.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              ptr;
  logic              grant0;
  logic              grant1;

  logic [DATA_W-1:0] op_a_p0;
  logic [DATA_W-1:0] op_b_p0;
  logic [3:0]        op_sel_p0;
  logic              op_id_p0;

  logic              vld_p1;
  logic              rsp_id_p1;
  logic [DATA_W-1:0] rsp_result_p1;
  logic [2:0]        rsp_flags_p1;
  logic              rsp_err_p1;

`ifdef ALU_ARB_SELCHK_EN
  function automatic logic sel_legal(input logic [3:0] sel);
    return (sel[0] == 1'b0) || (sel == 4'h1);
  endfunction
`endif

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant0 = bus.req0_valid && (!ptr || !bus.req1_valid);
    grant1 = bus.req1_valid && (ptr || !bus.req0_valid);
  end

  assign bus.req0_ready = (state == IDLE) && !rst && grant0;
  assign bus.req1_ready = (state == IDLE) && !rst && grant1;

  assign bus.alu_a      = op_a_p0;
  assign bus.alu_b      = op_b_p0;
  assign bus.alu_sel    = op_sel_p0;

  assign bus.rsp_valid  = vld_p1;
  assign bus.rsp_id     = rsp_id_p1;
  assign bus.rsp_result = rsp_result_p1;
  assign bus.rsp_flags  = rsp_flags_p1;
  assign bus.rsp_err    = rsp_err_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      op_a_p0       <= '0;
      op_b_p0       <= '0;
      op_sel_p0     <= '0;
      op_id_p0      <= 1'b0;
      vld_p1        <= 1'b0;
      rsp_id_p1     <= 1'b0;
      rsp_result_p1 <= '0;
      rsp_flags_p1  <= '0;
      rsp_err_p1    <= 1'b0;
    end else begin
      case (state)
        // p0: operands latched on grant, held otherwise
        IDLE: begin
          if (grant0 || grant1) begin
            op_a_p0   <= grant0 ? bus.req0_a   : bus.req1_a;
            op_b_p0   <= grant0 ? bus.req0_b   : bus.req1_b;
            op_sel_p0 <= grant0 ? bus.req0_sel : bus.req1_sel;
            op_id_p0  <= grant1;
            state     <= EXEC;
          end
        end
        // p1: ALU outputs captured into the response registers
        EXEC: begin
          vld_p1    <= 1'b1;
          rsp_id_p1 <= op_id_p0;
`ifdef ALU_ARB_SELCHK_EN
          if (!sel_legal(op_sel_p0)) begin
            rsp_result_p1 <= '0;
            rsp_flags_p1  <= '0;
            rsp_err_p1    <= 1'b1;
          end else begin
            rsp_result_p1 <= bus.alu_result;
            rsp_flags_p1  <= {bus.alu_carryOut, bus.alu_overflow, bus.alu_zero};
            rsp_err_p1    <= 1'b0;
          end
`else
          rsp_result_p1 <= bus.alu_result;
          rsp_flags_p1  <= {bus.alu_carryOut, bus.alu_overflow, bus.alu_zero};
          rsp_err_p1    <= 1'b0;
`endif
          state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            vld_p1 <= 1'b0;
            ptr    <= ~rsp_id_p1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Also models the shared combinational ALU that the arbiter drives.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(32)) bus();
  alu_arbiter #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic mptr;

  // Returns {result, carry, overflow, zero}; carry on SUB means "no borrow".
  function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; s = '0; r = '0;
    case (sel)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'h1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                  v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'h2: r = a & b;
      4'h4: r = a | b;
      4'h6: r = a ^ b;
      4'h8: r = a << b[4:0];
      4'hA: r = a >> b[4:0];
      4'hC: r = {31'd0, $signed(a) < $signed(b)};
      4'hE: r = {31'd0, a < b};
      default: r = a ^ ~b;
    endcase
    return {r, c, v, (r == 32'd0)};
  endfunction

  // Expected {result, flags, err} of a response for the given operation.
  function automatic logic [35:0] exp_rsp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel);
`ifdef ALU_ARB_SELCHK_EN
    if (!(sel inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE}))
      return {32'd0, 3'b000, 1'b1};
`endif
    return {alu_ref(a, b, sel), 1'b0};
  endfunction

  always_comb begin
    {bus.alu_result, bus.alu_carryOut, bus.alu_overflow, bus.alu_zero} =
      alu_ref(bus.alu_a, bus.alu_b, bus.alu_sel);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] sel);
    if (i == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mptr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'd4, 32'd5, 4'h0);
    set_req(1, 1'b1, 32'd6, 32'd7, 4'h2);
    tick();
    tick();
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_err} !== 6'd0) begin
      errors++; $display("FAIL reset_rsp_ctl got v%b id%b f%b e%b want all 0",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_err);
    end
    checks++;
    if (bus.rsp_result !== 32'd0) begin
      errors++; $display("FAIL reset_rsp_result got %h want 0", bus.rsp_result);
    end
    checks++;
    if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_sel !== 4'd0) begin
      errors++; $display("FAIL reset_alu got %h %h %h want 0 0 0", bus.alu_a, bus.alu_b, bus.alu_sel);
    end
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    rst = 1'b0;
    mptr = 1'b0;
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 32'd2, 32'd3, 4'h0);
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req0_valid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.alu_a !== 32'd2 || bus.alu_b !== 32'd3 || bus.alu_sel !== 4'h0) begin
      errors++; $display("FAIL single_exec got v%b a%h b%h s%h want v0 a2 b3 s0",
                         bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_sel);
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err} !== {1'b1, 1'b0, 32'd5, 3'b000, 1'b0}) begin
      errors++; $display("FAIL single_rsp got v%b id%b r%h f%b e%b want v1 id0 r5 f000 e0",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_done got v%b want 0", bus.rsp_valid);
    end
    mptr = 1'b1;
  endtask

  task automatic test_contention();
    apply_reset();
    set_req(0, 1'b1, 32'd2, 32'd3, 4'h1);
    set_req(1, 1'b1, 32'd2, 32'd3, 4'h2);
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++; $display("FAIL both_grant0 got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req0_valid = 1'b0;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++; $display("FAIL both_exec_ready got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.req0_ready, bus.req1_ready}
          !== {1'b1, 1'b0, 32'hFFFF_FFFF, 3'b000, 1'b0, 2'b00}) begin
        errors++; $display("FAIL hold_rsp cyc%0d got v%b id%b r%h f%b e%b rdy%b%b want v1 id0 rFFFFFFFF f000 e0 rdy00",
                           i, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err,
                           bus.req0_ready, bus.req1_ready);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'd1, 32'd1, 4'h0);
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      errors++; $display("FAIL both_grant1 got %b%b want 01", bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req1_valid = 1'b0;
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags} !== {1'b1, 1'b1, 32'd2, 3'b000}) begin
      errors++; $display("FAIL both_rsp1 got v%b id%b r%h f%b want v1 id1 r2 f000",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++; $display("FAIL both_regrant0 got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req0_valid = 1'b0;
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result} !== {1'b1, 1'b0, 32'd2}) begin
      errors++; $display("FAIL both_rsp0 got v%b id%b r%h want v1 id0 r2", bus.rsp_valid, bus.rsp_id, bus.rsp_result);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    mptr = 1'b1;
  endtask

  task automatic test_rst_exec();
    set_req(1, 1'b1, 32'd5, 32'd6, 4'h0);
    tick();
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rst_exec_norsp cyc%0d got v%b want 0", i, bus.rsp_valid);
      end
      tick();
    end
    set_req(0, 1'b1, 32'd7, 32'd8, 4'h0);
    set_req(1, 1'b1, 32'd9, 32'd1, 4'h1);
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rst_exec_ptr got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    tick();
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result} !== {1'b1, 1'b0, 32'd15}) begin
      errors++; $display("FAIL rst_exec_next got v%b id%b r%h want v1 id0 r0000000f", bus.rsp_valid, bus.rsp_id, bus.rsp_result);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    mptr = 1'b1;
  endtask

  task automatic test_ops();
    logic [31:0] ta [5] = '{32'd2, 32'hFFFF_FFFF, 32'd2, 32'h8000_0000, 32'hF0F0_F0F0};
    logic [31:0] tb [5] = '{32'd3, 32'd3, 32'd3, 32'd4, 32'h0FF0_0FF0};
    logic [3:0]  ts [5] = '{4'hC, 4'hE, 4'h8, 4'hA, 4'h6};
    logic [31:0] tw [5] = '{32'd1, 32'd0, 32'h10, 32'h0800_0000, 32'hFF00_FF00};
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1'b1, ta[i], tb[i], ts[i]);
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1) begin
        errors++; $display("FAIL ops_ready%0d got %b want 1", i, bus.req0_ready);
      end
      tick();
      bus.req0_valid = 1'b0;
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_result} !== {1'b1, tw[i]}) begin
        errors++; $display("FAIL ops_result%0d sel%h got v%b r%h want v1 r%h", i, ts[i], bus.rsp_valid, bus.rsp_result, tw[i]);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
    end
    mptr = 1'b1;
  endtask

  task automatic test_selchk();
    logic [35:0] want;
`ifdef ALU_ARB_SELCHK_EN
    want = {32'd0, 3'b000, 1'b1};
`else
    want = {32'hFFFF_FFFE, 3'b000, 1'b0};
`endif
    set_req(1, 1'b1, 32'd2, 32'd3, 4'h3);
    tick();
    bus.req1_valid = 1'b0;
    checks++;
    if (bus.alu_sel !== 4'h3) begin
      errors++; $display("FAIL selchk_alu_sel got %h want 3", bus.alu_sel);
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err} !== {1'b1, 1'b1, want}) begin
      errors++; $display("FAIL selchk_rsp got v%b id%b r%h f%b e%b want v1 id1 %h",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err, want);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    mptr = 1'b0;
  endtask

  // Randomized traffic: requesters hold their operation until granted.
  logic        rv [2];
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic [3:0]  rs [2];

  task automatic new_req(input int i);
    logic [3:0] legal [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE};
    rv[i] = ($urandom_range(0, 2) != 0);
    ra[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    rb[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    rs[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : legal[$urandom_range(0, 8)];
  endtask

  task automatic test_random();
    logic busy, in_exec, exp_id, g0, g1;
    logic [35:0] exp;
    apply_reset();
    busy = 1'b0; in_exec = 1'b0; exp_id = 1'b0; exp = '0;
    new_req(0);
    new_req(1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      set_req(0, rv[0], ra[0], rb[0], rs[0]);
      set_req(1, rv[1], ra[1], rb[1], rs[1]);
      bus.rsp_ready = 1'($urandom_range(0, 1));
      #1;
      g0 = !busy && rv[0] && (rv[1] ? !mptr : 1'b1);
      g1 = !busy && rv[1] && (rv[0] ? mptr : 1'b1);
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== {g0, g1}) begin
        errors++; $display("FAIL rand_ready cyc%0d got %b%b want %b%b", cyc, bus.req0_ready, bus.req1_ready, g0, g1);
      end
      checks++;
      if (bus.rsp_valid !== (busy && !in_exec)) begin
        errors++; $display("FAIL rand_rsp_valid cyc%0d got %b want %b", cyc, bus.rsp_valid, busy && !in_exec);
      end
      if (busy && !in_exec) begin
        checks++;
        if ({bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err} !== {exp_id, exp}) begin
          errors++; $display("FAIL rand_rsp cyc%0d got id%b r%h f%b e%b want id%b %h", cyc, bus.rsp_id,
                             bus.rsp_result, bus.rsp_flags, bus.rsp_err, exp_id, exp);
        end
      end
      if (g0 || g1) begin
        exp_id  = g1;
        exp     = g1 ? exp_rsp(ra[1], rb[1], rs[1]) : exp_rsp(ra[0], rb[0], rs[0]);
        busy    = 1'b1;
        in_exec = 1'b1;
        new_req(g1 ? 1 : 0);
      end else if (busy && in_exec) begin
        in_exec = 1'b0;
      end else if (busy && bus.rsp_ready) begin
        busy = 1'b0;
        mptr = ~exp_id;
      end
      for (int i = 0; i < 2; i++) if (!rv[i]) new_req(i);
      tick();
    end
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    mptr = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_rst_exec();
    test_ops();
    test_selchk();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
